// File: rtl/rn_pkg.sv
// ---------------------------------------------------------------------------
// rn_pkg
//   Shared sizing and types for the rename-stage free list.
//   NUM_PREG : physical registers = free-list depth (power of 2)
//   NUM_AREG : architectural registers; tags 0..NUM_AREG-1 start out mapped
//   PREG_W   : physical tag width
//   preg_t   : physical tag
//   fl_ptr_t : list pointer with an extra wrap bit (MSB)
// ---------------------------------------------------------------------------
package rn_pkg;

   localparam int NUM_PREG = 64;
   localparam int NUM_AREG = 32;
   localparam int PREG_W   = $clog2(NUM_PREG);

   typedef logic [PREG_W-1:0] preg_t;
   typedef logic [PREG_W:0]   fl_ptr_t;

   // Tail after reset: every non-architectural tag sits in the list.
   localparam fl_ptr_t INIT_TAIL = fl_ptr_t'(NUM_PREG - NUM_AREG);

   // Pointer advance by 0..2 slots; wrap bit toggles naturally on carry.
   function automatic fl_ptr_t ptr_add(input fl_ptr_t p, input logic [1:0] n);
      return p + fl_ptr_t'(n);
   endfunction

   // Table index of a pointer (drops the wrap bit).
   function automatic preg_t ptr_idx(input fl_ptr_t p);
      return p[PREG_W-1:0];
   endfunction

endpackage

// File: rtl/rn_free_list_ctrl_if.sv
// ---------------------------------------------------------------------------
// rn_free_list_ctrl_if
//   Bundle between the rename/commit logic (master) and the free-list
//   controller (slave).
//   flush                    : discard speculative allocations
//   alloc_req1/2             : Inst1/Inst2 need a destination tag
//   alloc_gnt                : every requested tag granted this cycle
//   alloc_preg1/2            : granted tags
//   rn_stall                 : hold the ID->RN register
//   ret_alloc1/2             : committing Inst1/Inst2 had allocated a tag
//   free_en1/2, free_preg1/2 : tags released at commit
//   free_count               : registered occupancy (tail - head)
//   fl_err                   : sticky overflow / duplicate-release flag
// ---------------------------------------------------------------------------
interface rn_free_list_ctrl_if;
   import rn_pkg::*;

   logic    flush;
   logic    alloc_req1;
   logic    alloc_req2;
   logic    alloc_gnt;
   preg_t   alloc_preg1;
   preg_t   alloc_preg2;
   logic    rn_stall;
   logic    ret_alloc1;
   logic    ret_alloc2;
   logic    free_en1;
   logic    free_en2;
   preg_t   free_preg1;
   preg_t   free_preg2;
   fl_ptr_t free_count;
   logic    fl_err;

   modport master (
      output flush, alloc_req1, alloc_req2,
      output ret_alloc1, ret_alloc2,
      output free_en1, free_en2, free_preg1, free_preg2,
      input  alloc_gnt, alloc_preg1, alloc_preg2, rn_stall,
      input  free_count, fl_err
   );

   modport slave (
      input  flush, alloc_req1, alloc_req2,
      input  ret_alloc1, ret_alloc2,
      input  free_en1, free_en2, free_preg1, free_preg2,
      output alloc_gnt, alloc_preg1, alloc_preg2, rn_stall,
      output free_count, fl_err
   );

endinterface

// File: rtl/rn_fl_ram.sv
// ---------------------------------------------------------------------------
// rn_fl_ram
//   NUM_PREG x PREG_W circular storage for free physical tags.
//   clk, rst           : clock, synchronous active-high reset
//   rd1_addr/rd1_data  : async read at head
//   rd2_addr/rd2_data  : async read at head+1
//   wr1_en/addr/data   : sync write at tail (wins on an address clash)
//   wr2_en/addr/data   : sync write at tail+1
//   Reset loads slot i with tag NUM_AREG+i for the first NUM_PREG-NUM_AREG
//   slots; the rest are unused until pushed.
// ---------------------------------------------------------------------------
module rn_fl_ram
   import rn_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  preg_t rd1_addr,
   output preg_t rd1_data,
   input  preg_t rd2_addr,
   output preg_t rd2_data,
   input  logic  wr1_en,
   input  preg_t wr1_addr,
   input  preg_t wr1_data,
   input  logic  wr2_en,
   input  preg_t wr2_addr,
   input  preg_t wr2_data
);

   preg_t mem [NUM_PREG];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_PREG; i++) begin
            mem[i] <= (i < NUM_PREG - NUM_AREG) ? preg_t'(NUM_AREG + i) : '0;
         end
      end else begin
         // Port 1 is written last so it wins if both target one slot.
         if (wr2_en) mem[wr2_addr] <= wr2_data;
         if (wr1_en) mem[wr1_addr] <= wr1_data;
      end
   end

   assign rd1_data = mem[rd1_addr];
   assign rd2_data = mem[rd2_addr];

endmodule

// File: rtl/rn_free_list_ctrl.sv
// ---------------------------------------------------------------------------
// rn_free_list_ctrl
//   Physical-register allocator for the 2-wide rename stage.
//   clk, rst : clock, synchronous active-high reset
//   fl       : slave side of rn_free_list_ctrl_if (alloc, release, flush,
//              occupancy and error status)
//   Grants are combinational from the registered head/tail; pointers move
//   on the clock edge. head tracks speculative allocation, commit_head tracks
//   committed allocation, and a flush rewinds head to commit_head.
// ---------------------------------------------------------------------------
module rn_free_list_ctrl
   import rn_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   rn_free_list_ctrl_if.slave fl
);

   fl_ptr_t    head, commit_head, tail;
   fl_ptr_t    count, room;
   logic [1:0] need, n_ret, n_free_req, n_free_acc;
   logic       gnt, overflow, dup_free, fl_err_q;
   preg_t      rd1_data, rd2_data;
   preg_t      wr1_data;
   logic       wr1_en, wr2_en;

   // Occupancy from registered pointers only; same-cycle frees are invisible.
   assign count = tail - head;
   assign room  = fl_ptr_t'(NUM_PREG) - count;

   assign need  = {1'b0, fl.alloc_req1} + {1'b0, fl.alloc_req2};
   assign n_ret = {1'b0, fl.ret_alloc1} + {1'b0, fl.ret_alloc2};

   // All-or-nothing grant; need==0 always grants (outside flush).
   assign gnt = (count >= fl_ptr_t'(need)) & ~fl.flush;

   // Accept as many pushes as there is room for; excess is dropped.
   always_comb begin
      n_free_req = {1'b0, fl.free_en1} + {1'b0, fl.free_en2};
      n_free_acc = '0;
      if (room >= fl_ptr_t'(2))      n_free_acc = n_free_req;
      else if (room == fl_ptr_t'(1)) n_free_acc = (n_free_req != 2'd0) ? 2'd1 : 2'd0;
   end

   assign overflow = (n_free_acc != n_free_req);
   assign dup_free = fl.free_en1 & fl.free_en2 & (fl.free_preg1 == fl.free_preg2);

   // A lone release always lands at tail; with both, preg1 goes first.
   assign wr1_en   = (n_free_acc != 2'd0);
   assign wr1_data = fl.free_en1 ? fl.free_preg1 : fl.free_preg2;
   assign wr2_en   = (n_free_acc == 2'd2);

   rn_fl_ram u_ram (
      .clk      (clk),
      .rst      (rst),
      .rd1_addr (ptr_idx(head)),
      .rd1_data (rd1_data),
      .rd2_addr (ptr_idx(ptr_add(head, 2'd1))),
      .rd2_data (rd2_data),
      .wr1_en   (wr1_en),
      .wr1_addr (ptr_idx(tail)),
      .wr1_data (wr1_data),
      .wr2_en   (wr2_en),
      .wr2_addr (ptr_idx(ptr_add(tail, 2'd1))),
      .wr2_data (fl.free_preg2)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         head        <= '0;
         commit_head <= '0;
         tail        <= INIT_TAIL;
         fl_err_q    <= 1'b0;
      end else begin
         commit_head <= ptr_add(commit_head, n_ret);
         // Flush rewinds to the committed point including this cycle's commits.
         if (fl.flush)  head <= ptr_add(commit_head, n_ret);
         else if (gnt)  head <= ptr_add(head, need);
         tail <= ptr_add(tail, n_free_acc);
         if (overflow | dup_free) fl_err_q <= 1'b1;
      end
   end

   assign fl.alloc_gnt   = gnt;
   assign fl.alloc_preg1 = rd1_data;
   // Inst2 takes the next slot only when Inst1 also consumes one.
   assign fl.alloc_preg2 = fl.alloc_req1 ? rd2_data : rd1_data;
   assign fl.rn_stall    = (fl.alloc_req1 | fl.alloc_req2) & ~gnt & ~fl.flush;
   assign fl.free_count  = count;
   assign fl.fl_err      = fl_err_q;

endmodule

// File: tb/tb_rn_free_list_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rn_free_list_ctrl
//   Scoreboard bench: the driver issues one cycle of stimulus, asks a
//   queue-based model of the free list what the DUT must show, and pushes
//   that into exp_q; the monitor pops and compares on the falling edge.
//   Model: free_q (allocatable tags in FIFO order), alloc_q (speculatively
//   allocated, oldest first), live_q (committed mappings that may be freed).
// ---------------------------------------------------------------------------
module tb_rn_free_list_ctrl;
   import rn_pkg::*;

   typedef struct {
      bit    gnt;
      bit    stall;
      bit    chk1;
      bit    chk2;
      preg_t p1;
      preg_t p2;
      int    cnt;
      bit    err;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rn_free_list_ctrl_if fl();

   rn_free_list_ctrl dut (
      .clk (clk),
      .rst (rst),
      .fl  (fl)
   );

   exp_t  exp_q[$];
   preg_t free_q[$];
   preg_t alloc_q[$];
   preg_t live_q[$];
   bit    m_err;
   int    errors = 0;
   int    checks = 0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      free_q.delete(); alloc_q.delete(); live_q.delete();
      for (int i = NUM_AREG; i < NUM_PREG; i++) free_q.push_back(preg_t'(i));
      for (int i = 0; i < NUM_AREG; i++)        live_q.push_back(preg_t'(i));
      m_err = 1'b0;
   endtask

   task automatic idle_inputs();
      fl.flush = 0; fl.alloc_req1 = 0; fl.alloc_req2 = 0;
      fl.ret_alloc1 = 0; fl.ret_alloc2 = 0;
      fl.free_en1 = 0; fl.free_en2 = 0; fl.free_preg1 = '0; fl.free_preg2 = '0;
   endtask

   // busy=1 drives every request during the reset cycle; reset must win.
   task automatic do_reset(input bit busy);
      @(posedge clk); #1;
      rst = 1;
      fl.flush = busy; fl.alloc_req1 = busy; fl.alloc_req2 = busy;
      fl.ret_alloc1 = busy; fl.ret_alloc2 = busy;
      fl.free_en1 = busy; fl.free_en2 = busy;
      fl.free_preg1 = 6'd5; fl.free_preg2 = 6'd9;
      @(posedge clk); #1;
      rst = 0;
      idle_inputs();
      model_reset();
   endtask

   function automatic preg_t take_live(input bit rnd);
      int    i;
      preg_t t;
      i = rnd ? $urandom_range(0, live_q.size() - 1) : 0;
      t = live_q[i];
      live_q.delete(i);
      return t;
   endfunction

   task automatic step(input bit r1, input bit r2, input bit c1, input bit c2,
                       input bit fe1, input preg_t fp1, input bit fe2, input preg_t fp2,
                       input bit fls);
      exp_t  e;
      int    need, cnt, nf, acc, nret;
      preg_t pend[$];
      @(posedge clk); #1;
      fl.alloc_req1 = r1; fl.alloc_req2 = r2;
      fl.ret_alloc1 = c1; fl.ret_alloc2 = c2;
      fl.free_en1 = fe1; fl.free_preg1 = fp1;
      fl.free_en2 = fe2; fl.free_preg2 = fp2;
      fl.flush = fls;
      need  = int'(r1) + int'(r2);
      nret  = int'(c1) + int'(c2);
      cnt   = free_q.size();
      e.gnt   = (cnt >= need) && !fls;
      e.stall = (r1 || r2) && !e.gnt && !fls;
      e.chk1  = e.gnt && r1;
      e.chk2  = e.gnt && r2;
      e.p1    = (cnt > 0) ? free_q[0] : '0;
      e.p2    = r1 ? ((cnt > 1) ? free_q[1] : '0) : e.p1;
      e.cnt   = cnt;
      e.err   = m_err;
      exp_q.push_back(e);
      // Advance the model to the post-edge state.
      if (fe1) pend.push_back(fp1);
      if (fe2) pend.push_back(fp2);
      nf  = pend.size();
      acc = (nf < NUM_PREG - cnt) ? nf : NUM_PREG - cnt;
      if (acc < nf) m_err = 1'b1;
      if (fe1 && fe2 && fp1 == fp2) m_err = 1'b1;
      if (e.gnt) repeat (need) alloc_q.push_back(free_q.pop_front());
      repeat (nret) live_q.push_back(alloc_q.pop_front());
      if (fls) while (alloc_q.size() > 0) free_q.push_front(alloc_q.pop_back());
      for (int i = 0; i < acc; i++) free_q.push_back(pend[i]);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, '0, 0, '0, 0);
   endtask

   // Monitor: compares whatever the driver queued for this cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("alloc_gnt",  int'(fl.alloc_gnt),  int'(e.gnt));
            chk("rn_stall",   int'(fl.rn_stall),   int'(e.stall));
            chk("free_count", int'(fl.free_count), e.cnt);
            chk("fl_err",     int'(fl.fl_err),     int'(e.err));
            if (e.chk1) chk("alloc_preg1", int'(fl.alloc_preg1), int'(e.p1));
            if (e.chk2) chk("alloc_preg2", int'(fl.alloc_preg2), int'(e.p2));
         end
      end
   end

   initial begin
      repeat (50000) @(posedge clk);
      $display("FAIL watchdog: got timeout expected completion");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      bit    r1, r2, c1, c2, fe1, fe2, fls;
      preg_t fp1, fp2;
      int    nret, nfr;
      rst = 1;
      idle_inputs();
      do_reset(0);

      // Reset state, then one pair allocation (expect 32/33, count 30 after).
      idle();
      step(1, 1, 0, 0, 0, '0, 0, '0, 0);
      idle();

      // Only Inst2 requests: gets 32.
      do_reset(0);
      step(0, 1, 0, 0, 0, '0, 0, '0, 0);
      idle();

      // Drain to one free tag, pair request stalls, a free lands, then grants.
      do_reset(0);
      repeat (15) step(1, 1, 0, 0, 0, '0, 0, '0, 0);
      step(1, 0, 0, 0, 0, '0, 0, '0, 0);
      step(1, 1, 0, 0, 0, '0, 0, '0, 0);
      fp1 = take_live(0);
      step(1, 1, 0, 0, 1, fp1, 0, '0, 0);
      step(1, 1, 0, 0, 0, '0, 0, '0, 0);
      idle();

      // Six allocations, two committed, flush with a pending request.
      do_reset(0);
      repeat (3) step(1, 1, 0, 0, 0, '0, 0, '0, 0);
      step(0, 0, 1, 0, 0, '0, 0, '0, 0);
      step(0, 0, 1, 0, 0, '0, 0, '0, 0);
      step(1, 1, 0, 0, 0, '0, 0, '0, 1);
      idle();
      step(1, 1, 0, 0, 0, '0, 0, '0, 0);

      // Steady alloc/commit/free of pairs across the index wrap.
      do_reset(0);
      for (int k = 0; k < 40; k++) begin
         c1  = (alloc_q.size() >= 2);
         fp1 = take_live(0);
         fp2 = take_live(0);
         step(1, 1, c1, c1, 1, fp1, 1, fp2, 0);
      end
      idle();

      // Duplicate tag in both release slots raises fl_err.
      do_reset(0);
      fp1 = take_live(0);
      step(0, 0, 0, 0, 1, fp1, 1, fp1, 0);
      idle();

      // Fill to 64, push once more, check stickiness, reset mid-stream.
      do_reset(0);
      repeat (16) begin
         fp1 = take_live(0);
         fp2 = take_live(0);
         step(0, 0, 0, 0, 1, fp1, 1, fp2, 0);
      end
      idle();
      step(0, 0, 0, 0, 1, 6'd0, 0, '0, 0);
      idle();
      idle();
      do_reset(1);
      idle();

      // Randomised legal traffic with occasional flushes.
      do_reset(0);
      for (int k = 0; k < 600; k++) begin
         r1   = ($urandom_range(0, 3) != 0);
         r2   = ($urandom_range(0, 3) != 0);
         nret = $urandom_range(0, (alloc_q.size() < 2) ? alloc_q.size() : 2);
         c1   = (nret == 2) || (nret == 1 && $urandom_range(0, 1) == 0);
         c2   = (nret == 2) || (nret == 1 && !c1);
         nfr  = $urandom_range(0, (live_q.size() < 2) ? live_q.size() : 2);
         fe1  = 0; fe2 = 0; fp1 = '0; fp2 = '0;
         if (nfr == 2) begin
            fe1 = 1; fe2 = 1; fp1 = take_live(1); fp2 = take_live(1);
         end else if (nfr == 1) begin
            if ($urandom_range(0, 1) == 0) begin fe1 = 1; fp1 = take_live(1); end
            else                           begin fe2 = 1; fp2 = take_live(1); end
         end
         fls = ($urandom_range(0, 19) == 0);
         step(r1, r2, c1, c2, fe1, fp1, fe2, fp2, fls);
      end
      idle();

      @(posedge clk); #1;
      idle_inputs();
      repeat (3) @(posedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
